// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state encoding for the 8-requester round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             preempt;

    modport master (output req, input gnt, gnt_id, gnt_valid, preempt);
    modport slave  (input req, output gnt, gnt_id, gnt_valid, preempt);
endinterface

// File: rtl/rr_arbiter_8_priority_encoder.sv
// 8-to-3 priority encoder: the highest set index wins; valid flags any set bit.
module priority_encoder_8x3
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);
    always_comb begin
        idx   = '0;
        valid = |vec;
        // Ascending scan so the last hit, i.e. the highest index, sticks.
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) idx = ID_W'(i);
        end
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with grant hold and timeout pre-emption.
// All outputs are registered; ptr remembers the last winner to rotate priority.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic           clk,
    input  logic           reset,
    rr_arbiter_8_if.slave  bus
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             preempt;

    logic             owner_req;
    logic             others;
    logic             timeout;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] low_mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] sel;
    logic [ID_W-1:0]  win;
    logic             win_valid;

    always_comb begin
        owner_req = bus.req[gnt_id];
        others    = |(bus.req & ~gnt);
        timeout   = (HOLD_MAX != 0) && (state == BUSY) && owner_req &&
                    (hold_cnt == HOLD_LAST) && others;
        // A timed-out owner is excluded so the encoder cannot re-pick it.
        cand      = timeout ? (bus.req & ~gnt) : bus.req;
        low_mask  = (N_REQ'(1) << ptr) - N_REQ'(1);
        masked    = cand & low_mask;
        sel       = (|masked) ? masked : cand;
    end

    priority_encoder_8x3 u_enc (
        .vec   (sel),
        .idx   (win),
        .valid (win_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state     <= BUSY;
                        gnt       <= N_REQ'(1) << win;
                        gnt_id    <= win;
                        gnt_valid <= 1'b1;
                        ptr       <= win;
                        hold_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (owner_req && !timeout) begin
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                    end else if (win_valid) begin
                        // Release or timeout handover: no idle bubble in between.
                        gnt      <= N_REQ'(1) << win;
                        gnt_id   <= win;
                        ptr      <= win;
                        hold_cnt <= '0;
                        preempt  <= timeout;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_id    = gnt_id;
    assign bus.gnt_valid = gnt_valid;
    assign bus.preempt   = preempt;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed plan steps plus random traffic on two
// instances (HOLD_MAX 4 and 3) checked against a scan-order reference model.
module tb_rr_arbiter_8;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    rr_arbiter_8_if bus4 ();
    rr_arbiter_8_if bus3 ();

    rr_arbiter_8 #(.HOLD_MAX(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    rr_arbiter_8 #(.HOLD_MAX(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    always #5 clk = ~clk;

    // Reference model: owner (-1 idle), last winner, cycles the owner has had
    // the grant including the coming one, and the expected preempt pulse.
    int m_owner [2];
    int m_ptr   [2];
    int m_held  [2];
    bit m_pre   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Priority order after last winner p: p-1 down to 0, then 7 down to p.
    function automatic int pick(input logic [7:0] v, input int p);
        for (int off = 1; off <= 8; off++) begin
            int i = (p - off) & 7;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_owner[j] = -1;
            m_ptr[j]   = 0;
            m_held[j]  = 0;
            m_pre[j]   = 1'b0;
        end
    endtask

    task automatic model_step(input int j, input logic [7:0] r);
        int h;
        int w;
        logic [7:0] rest;
        h = (j == 0) ? 4 : 3;
        m_pre[j] = 1'b0;
        if (m_owner[j] < 0 || !r[m_owner[j]]) begin
            w = pick(r, m_ptr[j]);
            if (w < 0) m_owner[j] = -1;
            else begin
                m_owner[j] = w;
                m_ptr[j]   = w;
                m_held[j]  = 1;
            end
        end else begin
            rest = r & ~(8'd1 << m_owner[j]);
            if (h != 0 && m_held[j] == h && rest != 8'd0) begin
                w = pick(rest, m_ptr[j]);
                m_owner[j] = w;
                m_ptr[j]   = w;
                m_held[j]  = 1;
                m_pre[j]   = 1'b1;
            end else begin
                m_held[j]++;
            end
        end
    endtask

    task automatic check_dut(input int j, input logic [7:0] g, input logic [2:0] id,
                             input logic v, input logic p);
        logic [7:0] eg;
        eg = (m_owner[j] < 0) ? 8'd0 : (8'd1 << m_owner[j]);
        chk($sformatf("dut%0d_gnt", j), 32'(g), 32'(eg));
        chk($sformatf("dut%0d_valid", j), 32'(v), 32'(m_owner[j] >= 0));
        chk($sformatf("dut%0d_preempt", j), 32'(p), 32'(m_pre[j]));
        if (m_owner[j] >= 0) chk($sformatf("dut%0d_gnt_id", j), 32'(id), 32'(m_owner[j]));
    endtask

    task automatic step(input logic [7:0] r);
        bus4.req = r;
        bus3.req = r;
        @(posedge clk);
        model_step(0, r);
        model_step(1, r);
        #1;
        check_dut(0, bus4.gnt, bus4.gnt_id, bus4.gnt_valid, bus4.preempt);
        check_dut(1, bus3.gnt, bus3.gnt_id, bus3.gnt_valid, bus3.preempt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt4"},   32'(bus4.gnt), 32'd0);
        chk({tag, "_id4"},    32'(bus4.gnt_id), 32'd0);
        chk({tag, "_valid4"}, 32'(bus4.gnt_valid), 32'd0);
        chk({tag, "_pre4"},   32'(bus4.preempt), 32'd0);
        chk({tag, "_gnt3"},   32'(bus3.gnt), 32'd0);
        chk({tag, "_valid3"}, 32'(bus3.gnt_valid), 32'd0);
    endtask

    initial begin
        int exp_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        logic [7:0] r;

        reset    = 1'b1;
        bus4.req = 8'h00;
        bus3.req = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        #2 reset = 1'b0;

        // Grant then handover with no idle bubble.
        step(8'h81);
        chk("t1_gnt", 32'(bus4.gnt), 32'h80);
        chk("t1_id", 32'(bus4.gnt_id), 32'd7);
        step(8'h01);
        chk("t1_hand_gnt", 32'(bus4.gnt), 32'h01);
        chk("t1_hand_valid", 32'(bus4.gnt_valid), 32'd1);
        step(8'h00);

        // All requesting, each owner releases right after its grant.
        step(8'hFF);
        chk("t2_first", 32'(bus4.gnt_id), 32'(exp_seq[0]));
        for (int i = 1; i < 9; i++) begin
            step(8'hFF & ~(8'd1 << exp_seq[i-1]));
            chk($sformatf("t2_seq%0d", i), 32'(bus4.gnt_id), 32'(exp_seq[i]));
        end
        step(8'h00);

        // Timeout rotation between 5 and 2 on the HOLD_MAX=4 instance.
        for (int c = 1; c <= 9; c++) begin
            step(8'h24);
            chk($sformatf("t3_gnt_c%0d", c), 32'(bus4.gnt),
                (c <= 4) ? 32'h20 : (c <= 8) ? 32'h04 : 32'h20);
            chk($sformatf("t3_pre_c%0d", c), 32'(bus4.preempt), 32'(c == 5 || c == 9));
        end

        // Lone owner past the timeout and past counter saturation keeps the grant.
        for (int c = 0; c < 270; c++) step(8'h08);
        chk("t4_gnt", 32'(bus4.gnt), 32'h08);
        for (int c = 0; c < 10; c++) begin
            step(8'h0C);
            chk("t4_sat_gnt", 32'(bus4.gnt), 32'h08);
            chk("t4_sat_pre", 32'(bus4.preempt), 32'd0);
        end
        step(8'h00);

        // Release on the timeout edge counts as a release.
        repeat (3) step(8'h06);
        chk("t5_pre_gnt", 32'(bus3.gnt), 32'h04);
        step(8'h02);
        chk("t5_gnt", 32'(bus3.gnt), 32'h02);
        chk("t5_pre", 32'(bus3.preempt), 32'd0);
        step(8'h00);

        // Asynchronous reset mid-grant, then full-vector priority.
        step(8'h10);
        chk("t6_gnt", 32'(bus4.gnt), 32'h10);
        #2 reset = 1'b1;
        #1 check_zero("t6_async");
        model_reset();
        @(negedge clk) reset = 1'b0;
        step(8'h11);
        chk("t6_after", 32'(bus4.gnt), 32'h10);

        // Random traffic; the current owner usually keeps requesting.
        for (int n = 0; n < 600; n++) begin
            r = 8'($urandom) & 8'($urandom);
            if (m_owner[0] >= 0 && $urandom_range(0, 9) < 8) r[m_owner[0]] = 1'b1;
            if ($urandom_range(0, 19) == 0) r = 8'h00;
            step(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
